// File: rtl/spi_mem_pkg.sv
// Shared constants, state encoding and status helpers for the SPI
// sample-memory readout sequencer and its RAM port arbiter.
package spi_mem_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    localparam int OPC_W = 4;
    localparam logic [OPC_W-1:0] OPC_READ   = 4'h1;
    localparam logic [OPC_W-1:0] OPC_STATUS = 4'h2;

    // Status field positions, counted down from the word MSB
    localparam int STAT_ERR_W   = 4;
    localparam int STAT_ERR_OFS = 0;
    localparam int STAT_UR_OFS  = 4;

    localparam logic [STAT_ERR_W-1:0] ERR_MAX = 4'hF;

    localparam int STARVE_LIM = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_FETCH,
        ST_STREAM,
        ST_STAT,
        ST_DISCARD
    } state_t;

    function automatic logic [STAT_ERR_W-1:0] err_next(
        input logic [STAT_ERR_W-1:0] cnt,
        input logic                  inc,
        input logic                  clr
    );
        if (clr) begin
            return {{(STAT_ERR_W-1){1'b0}}, inc};
        end
        if (inc && (cnt != ERR_MAX)) begin
            return cnt + 1'b1;
        end
        return cnt;
    endfunction

endpackage

// File: rtl/spi_mem_port_arb.sv
// Single RAM port shared by the capture writer and the SPI reader.
// Writer wins by default; a read that has lost twice wins outright.
module spi_mem_port_arb
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic              i_wr_req,
    input  logic [ADDR_W-1:0] i_wr_addr,
    output logic              o_rd_grant,
    output logic              o_wr_grant,
    output logic [ADDR_W-1:0] o_addr
);

    logic [1:0] r_wait;
    logic       w_starved;

    assign w_starved  = (r_wait == 2'(STARVE_LIM));
    assign o_rd_grant = i_rd_req & (~i_wr_req | w_starved);
    assign o_wr_grant = i_wr_req & ~o_rd_grant;

    always_comb begin
        o_addr = '0;
        if (o_rd_grant) begin
            o_addr = i_rd_addr;
        end else if (i_wr_req) begin
            o_addr = i_wr_addr;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wait <= '0;
        end else if (i_rd_req && !o_rd_grant) begin
            if (!w_starved) begin
                r_wait <= r_wait + 2'd1;
            end
        end else begin
            r_wait <= '0;
        end
    end

endmodule

// File: rtl/spi_mem_sequencer.sv
// SPI frame controller: decodes a command word, then streams RAM words
// MSB-first with one-word prefetch, or returns the status word.
module spi_mem_sequencer
    import spi_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_flag,
    input  logic              sel,
    input  logic              rising,
    input  logic              falling,
    input  logic              si,
    output logic              so,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int BC_W = $clog2(DATA_W);
    localparam logic [BC_W-1:0] BC_TOP = BC_W'(DATA_W - 1);

    state_t                r_state;
    logic [DATA_W-2:0]     r_cmd_sr;
    logic [DATA_W-1:0]     r_tx_word;
    logic [DATA_W-1:0]     r_next_word;
    logic                  r_next_valid;
    logic [BC_W-1:0]       r_bit_ctr;
    logic [ADDR_W-1:0]     r_rd_addr;
    logic [ADDR_W-1:0]     r_req_addr;
    logic                  r_rd_req;
    logic                  r_req_next;
    logic                  r_infl;
    logic                  r_infl_next;
    logic                  r_so;
    logic [STAT_ERR_W-1:0] r_err_cnt;
    logic                  r_underrun;

    logic                  w_rd_grant;
    logic                  w_wr_grant;
    logic [ADDR_W-1:0]     w_arb_addr;
    logic [DATA_W-1:0]     w_cmd;
    logic [OPC_W-1:0]      w_opc;
    logic [DATA_W-1:0]     w_status;
    logic                  w_last;
    logic                  w_err_inc;
    logic                  w_ur_set;
    logic                  w_clr;

    spi_mem_port_arb #(
        .ADDR_W (ADDR_W)
    ) u_arb (
        .i_clk      (clk),
        .i_rst      (reset_flag),
        .i_rd_req   (r_rd_req),
        .i_rd_addr  (r_req_addr),
        .i_wr_req   (wr_req),
        .i_wr_addr  (wr_addr),
        .o_rd_grant (w_rd_grant),
        .o_wr_grant (w_wr_grant),
        .o_addr     (w_arb_addr)
    );

    assign so        = r_so;
    assign busy      = (r_state != ST_IDLE);
    assign wr_ack    = w_wr_grant;
    assign mem_we    = w_wr_grant;
    assign mem_addr  = w_arb_addr;
    assign mem_wdata = wr_data;

    assign w_cmd  = {r_cmd_sr, si};
    assign w_opc  = w_cmd[DATA_W-1 -: OPC_W];
    assign w_last = (r_bit_ctr == '0);

    always_comb begin
        w_status = '0;
        w_status[DATA_W-1-STAT_ERR_OFS -: STAT_ERR_W] = r_err_cnt;
        w_status[DATA_W-1-STAT_UR_OFS] = r_underrun;
    end

    assign w_err_inc = sel && (r_state == ST_CMD) && rising && w_last
                       && (w_opc != OPC_READ) && (w_opc != OPC_STATUS);
    assign w_ur_set  = sel && (r_state == ST_STREAM) && falling && w_last
                       && !r_next_valid;
    // Status is consumed when the frame that read it closes
    assign w_clr     = !sel && (r_state == ST_STAT);

    always_ff @(posedge clk or posedge reset_flag) begin
        if (reset_flag) begin
            r_err_cnt  <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_err_cnt  <= err_next(r_err_cnt, w_err_inc, w_clr);
            r_underrun <= w_clr ? w_ur_set : (r_underrun | w_ur_set);
        end
    end

    always_ff @(posedge clk or posedge reset_flag) begin
        if (reset_flag) begin
            r_state      <= ST_IDLE;
            r_cmd_sr     <= '0;
            r_tx_word    <= '0;
            r_next_word  <= '0;
            r_next_valid <= 1'b0;
            r_bit_ctr    <= '0;
            r_rd_addr    <= '0;
            r_req_addr   <= '0;
            r_rd_req     <= 1'b0;
            r_req_next   <= 1'b0;
            r_infl       <= 1'b0;
            r_infl_next  <= 1'b0;
            r_so         <= 1'b0;
        end else begin
            if (w_rd_grant) begin
                r_rd_req    <= 1'b0;
                r_infl      <= 1'b1;
                r_infl_next <= r_req_next;
            end else begin
                r_infl <= 1'b0;
            end

            if (!sel) begin
                r_state      <= ST_IDLE;
                r_so         <= 1'b0;
                r_rd_req     <= 1'b0;
                r_infl       <= 1'b0;
                r_next_valid <= 1'b0;
            end else begin
                unique case (r_state)
                    ST_IDLE: begin
                        r_state   <= ST_CMD;
                        r_cmd_sr  <= '0;
                        r_bit_ctr <= BC_TOP;
                        r_so      <= 1'b0;
                    end
                    ST_CMD: begin
                        if (rising) begin
                            r_cmd_sr  <= w_cmd[DATA_W-2:0];
                            r_bit_ctr <= r_bit_ctr - 1'b1;
                            if (w_last) begin
                                r_bit_ctr <= BC_TOP;
                                if (w_opc == OPC_READ) begin
                                    r_rd_addr  <= w_cmd[ADDR_W-1:0];
                                    r_req_addr <= w_cmd[ADDR_W-1:0];
                                    r_rd_req   <= 1'b1;
                                    r_req_next <= 1'b0;
                                    r_state    <= ST_FETCH;
                                end else if (w_opc == OPC_STATUS) begin
                                    r_tx_word <= w_status;
                                    r_state   <= ST_STAT;
                                end else begin
                                    r_state <= ST_DISCARD;
                                end
                            end
                        end
                    end
                    ST_FETCH: begin
                        if (r_infl && !r_infl_next) begin
                            r_tx_word  <= mem_rdata;
                            r_rd_req   <= 1'b1;
                            r_req_next <= 1'b1;
                            r_req_addr <= r_rd_addr + ADDR_W'(1);
                            r_state    <= ST_STREAM;
                        end
                    end
                    ST_STREAM: begin
                        if (r_infl && r_infl_next) begin
                            r_next_word  <= mem_rdata;
                            r_next_valid <= 1'b1;
                        end
                        if (falling) begin
                            r_so      <= r_tx_word[r_bit_ctr];
                            r_bit_ctr <= r_bit_ctr - 1'b1;
                            if (w_last) begin
                                r_bit_ctr    <= BC_TOP;
                                r_rd_addr    <= r_rd_addr + ADDR_W'(1);
                                r_tx_word    <= r_next_valid ? r_next_word : '0;
                                r_next_valid <= 1'b0;
                                r_rd_req     <= 1'b1;
                                r_req_next   <= 1'b1;
                                r_req_addr   <= r_rd_addr + ADDR_W'(2);
                            end
                        end
                    end
                    ST_STAT: begin
                        if (falling) begin
                            r_so      <= r_tx_word[r_bit_ctr];
                            r_bit_ctr <= r_bit_ctr - 1'b1;
                            if (w_last) begin
                                r_bit_ctr <= BC_TOP;
                                r_tx_word <= '0;
                            end
                        end
                    end
                    ST_DISCARD: begin
                        r_so <= 1'b0;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_sequencer.sv
// Directed bench for spi_mem_sequencer: SPI master, behavioural RAM,
// immediate-assertion checks with hand-computed expectations.
module tb_spi_mem_sequencer;
    import spi_mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset_flag;
    logic        sel;
    logic        rising;
    logic        falling;
    logic        si;
    logic        so;
    logic        wr_req;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        busy;

    logic [15:0] ram [0:4095];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    spi_mem_sequencer #(
        .ADDR_W (12),
        .DATA_W (16)
    ) dut (
        .clk        (clk),
        .reset_flag (reset_flag),
        .sel        (sel),
        .rising     (rising),
        .falling    (falling),
        .si         (si),
        .so         (so),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    always @(posedge clk) begin
        if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [11:0] a, input logic [15:0] d);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        #1;
        check("preload_ack", wr_ack, 1);
        tick();
        wr_req = 1'b0;
    endtask

    task automatic pair(input logic b, input logic chk,
                        input logic [11:0] ra, output logic sb);
        si = b;
        repeat (6) tick();
        rising = 1'b1;
        tick();
        rising = 1'b0;
        if (chk) check("starve_wr0", wr_ack, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (chk && i == 0) check("starve_wr1", wr_ack, 1);
            if (chk && i == 1) check("starve_rd", {wr_ack, mem_addr}, {1'b0, ra});
            if (chk && i == 2) check("starve_wdone", mem_we, 1);
        end
        falling = 1'b1;
        tick();
        falling = 1'b0;
        sb = so;
    endtask

    task automatic frame_open();
        sel = 1'b1;
        tick();
        tick();
    endtask

    task automatic frame_close(input string tag);
        tick();
        tick();
        sel = 1'b0;
        tick();
        tick();
        check({tag, "_so_idle"}, so, 0);
        check({tag, "_busy_idle"}, busy, 0);
    endtask

    task automatic run(input string tag, input logic [15:0] cmd, input int ndata,
                       input logic chk, output logic [63:0] rx);
        logic sb;
        rx = '0;
        frame_open();
        for (int k = 1; k <= 15 + ndata; k++) begin
            pair((k <= 16) ? cmd[16-k] : 1'b0, chk && (k == 16), cmd[11:0], sb);
            if (k >= 16) rx = {rx[62:0], sb};
        end
        frame_close(tag);
    endtask

    initial begin
        logic [63:0] rx;
        logic        sb;
        reset_flag = 1'b1;
        sel        = 1'b0;
        rising     = 1'b0;
        falling    = 1'b0;
        si         = 1'b0;
        wr_req     = 1'b0;
        wr_addr    = '0;
        wr_data    = '0;
        tick();
        check("rst_so", so, 0);
        check("rst_busy", busy, 0);
        check("rst_we", mem_we, 0);
        check("rst_ack", wr_ack, 0);
        check("rst_addr", mem_addr, 0);
        reset_flag = 1'b0;
        tick();

        wr(12'h010, 16'hA5C3);
        wr(12'h011, 16'h1234);
        wr(12'h012, 16'h5A5A);
        wr(12'hFFF, 16'hBEEF);
        wr(12'h000, 16'h0F0F);
        wr(12'h020, 16'hCAFE);
        wr(12'h030, 16'h9C3E);
        wr(12'h031, 16'h0001);

        run("rd10", {OPC_READ, 12'h010}, 48, 1'b0, rx);
        check("rd10_data", rx[47:0], 48'hA5C3_1234_5A5A);

        run("rdwrap", {OPC_READ, 12'hFFF}, 32, 1'b0, rx);
        check("rdwrap_data", rx[31:0], 32'hBEEF_0F0F);

        wr_req  = 1'b1;
        wr_addr = 12'h200;
        wr_data = 16'h7777;
        run("starve", {OPC_READ, 12'h030}, 32, 1'b1, rx);
        wr_req = 1'b0;
        check("starve_data", rx[31:0], 32'h9C3E_0001);
        tick();
        check("starve_wmem", ram[12'h200], 16'h7777);

        for (int f = 0; f < 3; f++) begin
            run("bad", 16'h7123, 1, 1'b0, rx);
            check("bad_so", rx[0], 0);
        end
        run("stat1", {OPC_STATUS, 12'h000}, 20, 1'b0, rx);
        check("stat1_word", rx[19:0], 20'h30000);
        run("stat2", {OPC_STATUS, 12'h000}, 16, 1'b0, rx);
        check("stat2_word", rx[15:0], 16'h0000);

        run("trunc", {OPC_READ, 12'h010}, 5, 1'b0, rx);
        check("trunc_bits", rx[4:0], 5'b10100);
        run("rd20", {OPC_READ, 12'h020}, 16, 1'b0, rx);
        check("rd20_data", rx[15:0], 16'hCAFE);

        rx = '0;
        frame_open();
        for (int k = 1; k <= 18; k++) begin
            pair((k <= 16) ? 1'((16'h1010 >> (16 - k))) : 1'b0, 1'b0, 12'h0, sb);
            if (k >= 16) rx = {rx[62:0], sb};
        end
        check("mid_bits", rx[2:0], 3'b101);
        check("mid_busy", busy, 1);
        #2;
        reset_flag = 1'b1;
        wr_req     = 1'b1;
        wr_addr    = 12'h300;
        wr_data    = 16'h4242;
        #1;
        check("arst_so", so, 0);
        check("arst_busy", busy, 0);
        check("arst_ack", wr_ack, 1);
        check("arst_we_addr", {mem_we, mem_addr}, {1'b1, 12'h300});
        tick();
        reset_flag = 1'b0;
        wr_req     = 1'b0;
        sel        = 1'b0;
        tick();
        tick();
        check("arst_wmem", ram[12'h300], 16'h4242);
        run("post", {OPC_READ, 12'h020}, 16, 1'b0, rx);
        check("post_data", rx[15:0], 16'hCAFE);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
